// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO with valid/ready
// handshakes on both sides, flush/hold controls and a saturating stall counter.
module pipe_stage_buffer #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 2,
  parameter int STALL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  input  logic                       hold,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [STALL_W-1:0]         stall_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // A single-entry buffer still needs a 1-bit pointer; it simply never moves.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wp;
  logic [PTR_W-1:0]   r_rp;
  logic [CNT_W-1:0]   r_count;
  logic [STALL_W-1:0] r_stall;

  logic w_push;
  logic w_pop;
  logic w_stall;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake outputs depend only on registered state and the control inputs,
  // so there is no combinational path from out_ready to in_ready.
  assign in_ready  = rst_n && !flush && (r_count < DEPTH_C);
  assign out_valid = rst_n && (r_count != '0) && !hold && !flush;
  assign out_data  = r_mem[r_rp];

  assign w_push  = in_valid && in_ready;
  assign w_pop   = out_valid && out_ready;
  assign w_stall = (r_count != '0) && !flush && (hold || !out_ready);

  assign count     = r_count;
  assign stall_cnt = r_stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= next_ptr(r_wp);
      if (w_pop)  r_rp <= next_ptr(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the payload array is cleared on reset so out_data reads 0 afterwards;
  // flush deliberately leaves it untouched since only the pointers matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wp] <= in_data;
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

endmodule
